// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry constants, direction and mover state types
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int PIECE_WIN  = 4;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_DROP  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DROP  = 2'd2,
        ST_LOCK  = 2'd3
    } mover_state_e;

endpackage

// File: rtl/piece_fit_check.sv
// rtl/piece_fit_check.sv - edge and collision test of a candidate piece window against the board
module piece_fit_check
    import tetris_pkg::*;
#(
    parameter int ROWS  = BOARD_ROWS,
    parameter int COLS  = BOARD_COLS,
    parameter int WIN   = PIECE_WIN,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic [ROWS*COLS-1:0] board_i,
    input  logic [WIN*COLS-1:0]  cur_shape_i,
    input  logic [ROW_W-1:0]     cur_row_i,
    input  logic [WIN*COLS-1:0]  cand_shape_i,
    input  logic [ROW_W-1:0]     cand_row_i,
    input  dir_e                 dir_i,
    output logic                 at_edge_o,
    output logic                 collide_o
);

    localparam int IDX_W = $clog2(ROWS*COLS);

    // One bit per window row at the leftmost / rightmost column.
    localparam logic [WIN*COLS-1:0] MSB_MASK = {WIN{1'b1, {(COLS-1){1'b0}}}};
    localparam logic [WIN*COLS-1:0] LSB_MASK = {WIN{{(COLS-1){1'b0}}, 1'b1}};

    logic [WIN*COLS-1:0] win_bits;
    int                  win_row;
    logic [IDX_W-1:0]    win_base;

    // Gather the board rows under the candidate; rows past the top read as empty.
    always_comb begin
        win_bits = '0;
        win_row  = 0;
        win_base = '0;
        for (int i = 0; i < WIN; i++) begin
            win_row = int'(cand_row_i) + i;
            if (win_row < ROWS) begin
                win_base = IDX_W'(win_row * COLS);
                win_bits[i*COLS +: COLS] = board_i[win_base +: COLS];
            end
        end
    end

    // Edge test looks at the current piece, so a shift that would push cells off the board is caught.
    always_comb begin
        case (dir_i)
            DIR_LEFT:  at_edge_o = |(cur_shape_i & MSB_MASK);
            DIR_RIGHT: at_edge_o = |(cur_shape_i & LSB_MASK);
            default:   at_edge_o = (cur_row_i == '0);
        endcase
        collide_o = |(cand_shape_i & win_bits);
    end

endmodule

// File: rtl/piece_mover.sv
// rtl/piece_mover.sv - board owner and active-piece move/lock engine; hard drop built with PIECE_MOVER_HARD_DROP_EN
module piece_mover
    import tetris_pkg::*;
#(
    parameter int ROWS  = BOARD_ROWS,
    parameter int COLS  = BOARD_COLS,
    parameter int WIN   = PIECE_WIN,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic [WIN*COLS-1:0]  load_shape,
    input  logic [ROW_W-1:0]     load_row,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_dir,
    output logic [ROWS*COLS-1:0] board,
    output logic [WIN*COLS-1:0]  piece_shape,
    output logic [ROW_W-1:0]     piece_row,
    output logic                 piece_active,
    output logic                 done,
    output logic                 moved,
    output logic                 locked,
    output logic [ROW_W-1:0]     drop_rows,
    output logic                 game_over
);

    localparam int IDX_W = $clog2(ROWS*COLS);
`ifdef PIECE_MOVER_HARD_DROP_EN
    localparam logic [ROW_W-1:0] DROP_MAX = ROW_W'(ROWS - 1);
`endif

    mover_state_e        state_q;
    dir_e                dir_q;
    logic [ROWS*COLS-1:0] board_q;
    logic [WIN*COLS-1:0] shape_q;
    logic [ROW_W-1:0]    row_q;
    logic                active_q;
    logic                done_q;
    logic                moved_q;
    logic                locked_q;
    logic [ROW_W-1:0]    drop_rows_q;
    logic                game_over_q;

    dir_e                eff_dir;
    logic [WIN*COLS-1:0] cand_shape;
    logic [ROW_W-1:0]    cand_row;
    logic [WIN*COLS-1:0] chk_shape;
    logic [ROW_W-1:0]    chk_row;
    logic                at_edge;
    logic                collide;
    logic                fit;
    logic [ROWS*COLS-1:0] board_d;
    int                  lk_row;
    logic [IDX_W-1:0]    lk_base;

    // Candidate position for the pending move; the DROP state always probes one row down.
    always_comb begin
        eff_dir    = (state_q == ST_DROP) ? DIR_DOWN : dir_q;
        cand_shape = shape_q;
        cand_row   = row_q;
        case (eff_dir)
            DIR_LEFT: begin
                for (int i = 0; i < WIN; i++) begin
                    cand_shape[i*COLS +: COLS] = shape_q[i*COLS +: COLS] << 1;
                end
            end
            DIR_RIGHT: begin
                for (int i = 0; i < WIN; i++) begin
                    cand_shape[i*COLS +: COLS] = shape_q[i*COLS +: COLS] >> 1;
                end
            end
            default: cand_row = row_q - ROW_W'(1);
        endcase
    end

    // The single checker serves the spawn overlap test while idle and the move test otherwise.
    always_comb begin
        chk_shape = (state_q == ST_IDLE) ? load_shape : cand_shape;
        chk_row   = (state_q == ST_IDLE) ? load_row   : cand_row;
        fit       = !at_edge && !collide;
    end

    piece_fit_check #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .WIN   (WIN),
        .ROW_W (ROW_W)
    ) u_fit (
        .board_i      (board_q),
        .cur_shape_i  (shape_q),
        .cur_row_i    (row_q),
        .cand_shape_i (chk_shape),
        .cand_row_i   (chk_row),
        .dir_i        (eff_dir),
        .at_edge_o    (at_edge),
        .collide_o    (collide)
    );

    // Board with the active piece merged in at its current row, used on lock.
    always_comb begin
        board_d = board_q;
        lk_row  = 0;
        lk_base = '0;
        for (int i = 0; i < WIN; i++) begin
            lk_row = int'(row_q) + i;
            if (lk_row < ROWS) begin
                lk_base = IDX_W'(lk_row * COLS);
                board_d[lk_base +: COLS] = board_q[lk_base +: COLS] | shape_q[i*COLS +: COLS];
            end
        end
    end

    // Mover FSM: spawn, command accept, fit check, hard drop walk and lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_LEFT;
            board_q     <= '0;
            shape_q     <= '0;
            row_q       <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            moved_q     <= 1'b0;
            locked_q    <= 1'b0;
            drop_rows_q <= '0;
            game_over_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        shape_q <= load_shape;
                        row_q   <= load_row;
                        if (collide) begin
                            game_over_q <= 1'b1;
                            active_q    <= 1'b0;
                        end else begin
                            active_q <= 1'b1;
                        end
                    end else if (cmd_valid && cmd_ready) begin
                        dir_q   <= dir_e'(cmd_dir);
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    case (dir_q)
                        DIR_LEFT, DIR_RIGHT: begin
                            done_q      <= 1'b1;
                            moved_q     <= fit;
                            drop_rows_q <= '0;
                            if (fit) begin
                                shape_q <= cand_shape;
                            end
                        end
                        DIR_DOWN: begin
                            if (fit) begin
                                row_q       <= cand_row;
                                drop_rows_q <= ROW_W'(1);
                                done_q      <= 1'b1;
                                moved_q     <= 1'b1;
                            end else begin
                                drop_rows_q <= '0;
                                state_q     <= ST_LOCK;
                            end
                        end
                        default: begin
`ifdef PIECE_MOVER_HARD_DROP_EN
                            // First step of the drop happens here so a drop of n rows finishes at T3+n.
                            if (fit) begin
                                row_q       <= cand_row;
                                drop_rows_q <= ROW_W'(1);
                                state_q     <= ST_DROP;
                            end else begin
                                drop_rows_q <= '0;
                                state_q     <= ST_LOCK;
                            end
`else
                            done_q      <= 1'b1;
                            moved_q     <= 1'b0;
                            drop_rows_q <= '0;
`endif
                        end
                    endcase
                end
`ifdef PIECE_MOVER_HARD_DROP_EN
                ST_DROP: begin
                    if (fit) begin
                        row_q <= cand_row;
                        if (drop_rows_q != DROP_MAX) begin
                            drop_rows_q <= drop_rows_q + ROW_W'(1);
                        end
                    end else begin
                        state_q <= ST_LOCK;
                    end
                end
`endif
                ST_LOCK: begin
                    board_q  <= board_d;
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                    locked_q <= 1'b1;
                    moved_q  <= (drop_rows_q != '0);
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE) && active_q && !load_valid && !game_over_q;
    assign board        = board_q;
    assign piece_shape  = shape_q;
    assign piece_row    = row_q;
    assign piece_active = active_q;
    assign done         = done_q;
    assign moved        = moved_q;
    assign locked       = locked_q;
    assign drop_rows    = drop_rows_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_piece_mover.sv
// tb/tb_piece_mover.sv - randomized self-checking bench for piece_mover against a row-array game model
module tb_piece_mover;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int WIN   = 4;
    localparam int ROW_W = 5;

    localparam logic [WIN*COLS-1:0] O_PC   = {20'h0, 10'b0000110000, 10'b0000110000};
    localparam logic [WIN*COLS-1:0] BAR_PC = {30'h0, 10'h3FF};
    localparam logic [WIN*COLS-1:0] R_PC   = {30'h0, 10'b0000000011};
    localparam logic [WIN*COLS-1:0] R_PC_L = {30'h0, 10'b0000000110};

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 load_valid;
    logic [WIN*COLS-1:0]  load_shape;
    logic [ROW_W-1:0]     load_row;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_dir;
    logic [ROWS*COLS-1:0] board;
    logic [WIN*COLS-1:0]  piece_shape;
    logic [ROW_W-1:0]     piece_row;
    logic                 piece_active;
    logic                 done;
    logic                 moved;
    logic                 locked;
    logic [ROW_W-1:0]     drop_rows;
    logic                 game_over;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    piece_mover dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_shape   (load_shape),
        .load_row     (load_row),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .board        (board),
        .piece_shape  (piece_shape),
        .piece_row    (piece_row),
        .piece_active (piece_active),
        .done         (done),
        .moved        (moved),
        .locked       (locked),
        .drop_rows    (drop_rows),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    // Game model: the board and piece as arrays of rows, the result of a command worked out at once.
    logic [COLS-1:0] m_board [ROWS];
    logic [COLS-1:0] m_shape [WIN];
    int m_row;
    bit m_active, m_go, m_busy;
    int m_cnt;
    logic [COLS-1:0] p_board [ROWS];
    logic [COLS-1:0] p_shape [WIN];
    int p_row, p_drop;
    bit p_active, p_moved, p_locked, p_is_drop;
    bit e_done, e_moved, e_locked;
    int e_drop;

    function automatic bit m_fits(input logic [COLS-1:0] sh [WIN], input int r);
        for (int i = 0; i < WIN; i++) begin
            if (r + i < ROWS && (sh[i] & m_board[r + i]) != '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_lock(input int r);
        for (int i = 0; i < WIN; i++) begin
            if (r + i < ROWS) p_board[r + i] = p_board[r + i] | m_shape[i];
        end
        p_active = 1'b0;
        p_locked = 1'b1;
    endtask

    task automatic m_accept(input int d);
        logic [COLS-1:0] sh [WIN];
        bit blk;
        int r, n;
        p_board = m_board;
        p_shape = m_shape;
        p_row = m_row;
        p_active = 1'b1;
        p_moved = 1'b0;
        p_locked = 1'b0;
        p_drop = 0;
        p_is_drop = 1'b0;
        m_cnt = 1;
        if (d == 0 || d == 1) begin
            blk = 1'b0;
            for (int i = 0; i < WIN; i++) begin
                if (d == 0) begin
                    blk = blk | m_shape[i][COLS-1];
                    sh[i] = m_shape[i] << 1;
                end else begin
                    blk = blk | m_shape[i][0];
                    sh[i] = m_shape[i] >> 1;
                end
            end
            if (!blk && m_fits(sh, m_row)) begin
                p_shape = sh;
                p_moved = 1'b1;
            end
        end else if (d == 2) begin
            if (m_row > 0 && m_fits(m_shape, m_row - 1)) begin
                p_row = m_row - 1;
                p_moved = 1'b1;
                p_drop = 1;
            end else begin
                m_lock(m_row);
                m_cnt = 2;
            end
        end else begin
`ifdef PIECE_MOVER_HARD_DROP_EN
            r = m_row;
            n = 0;
            while (r > 0 && m_fits(m_shape, r - 1)) begin
                r--;
                n++;
            end
            p_row = r;
            m_lock(r);
            p_drop = (n > ROWS - 1) ? ROWS - 1 : n;
            p_moved = (n != 0);
            p_is_drop = 1'b1;
            m_cnt = 2 + n;
`else
            r = 0;
            n = 0;
`endif
        end
        m_busy = 1'b1;
    endtask

    // Model update on each rising edge from the inputs presented in the cycle before it.
    always @(posedge clk) begin
        e_done = 1'b0;
        e_locked = 1'b0;
        if (reset) begin
            for (int r = 0; r < ROWS; r++) m_board[r] = '0;
            for (int i = 0; i < WIN; i++) m_shape[i] = '0;
            m_row = 0;
            m_active = 1'b0;
            m_go = 1'b0;
            m_busy = 1'b0;
            p_is_drop = 1'b0;
            e_moved = 1'b0;
            e_drop = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_board = p_board;
                m_shape = p_shape;
                m_row = p_row;
                m_active = p_active;
                m_busy = 1'b0;
                e_done = 1'b1;
                e_moved = p_moved;
                e_locked = p_locked;
                e_drop = p_drop;
            end
        end else if (load_valid) begin
            for (int i = 0; i < WIN; i++) m_shape[i] = load_shape[i*COLS +: COLS];
            m_row = int'(load_row);
            if (!m_fits(m_shape, m_row)) begin
                m_go = 1'b1;
                m_active = 1'b0;
            end else begin
                m_active = 1'b1;
            end
        end else if (cmd_valid && m_active && !m_go) begin
            m_accept(int'(cmd_dir));
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [ROWS*COLS-1:0] eb;
    logic [WIN*COLS-1:0]  es;
    bit er;

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int r = 0; r < ROWS; r++) eb[r*COLS +: COLS] = m_board[r];
            for (int i = 0; i < WIN; i++) es[i*COLS +: COLS] = m_shape[i];
            er = !m_busy && m_active && !load_valid && !m_go;
            chk("board", board, eb);
            chk("piece_shape", piece_shape, es);
            chk("piece_active", piece_active, m_active);
            chk("done", done, e_done);
            chk("locked", locked, e_locked);
            chk("game_over", game_over, m_go);
            chk("cmd_ready", cmd_ready, er);
            if (!(m_busy && p_is_drop)) chk("piece_row", piece_row, m_row[ROW_W-1:0]);
            if (e_done) begin
                chk("moved", moved, e_moved);
                chk("drop_rows", drop_rows, e_drop[ROW_W-1:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (m_busy && g < 200) begin
            tick();
            g++;
        end
        if (m_busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy expected idle within 200 cycles");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [WIN*COLS-1:0] s, input int r);
        load_valid = 1'b1;
        load_shape = s;
        load_row = r[ROW_W-1:0];
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_cmd(input int d);
        cmd_valid = 1'b1;
        cmd_dir = d[1:0];
        tick();
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    function automatic logic [WIN*COLS-1:0] rand_piece();
        logic [15:0] pat;
        logic [COLS-1:0] rw;
        logic [WIN*COLS-1:0] s;
        int sh;
        case ($urandom_range(0, 4))
            0: pat = 16'h000F;
            1: pat = 16'h0033;
            2: pat = 16'h0027;
            3: pat = 16'h0063;
            default: pat = 16'h0113;
        endcase
        sh = $urandom_range(0, 6);
        s = '0;
        for (int i = 0; i < WIN; i++) begin
            rw = COLS'(pat[i*4 +: 4]);
            s[i*COLS +: COLS] = rw << sh;
        end
        return s;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        load_valid = 1'b0;
        load_shape = '0;
        load_row = '0;
        cmd_valid = 1'b0;
        cmd_dir = 2'd0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_board", board, 0);
        chk("rst_active", piece_active, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_game_over", game_over, 0);

        // O-piece one row down.
        do_load(O_PC, 16);
        do_cmd(2);
        chk("down_done", done, 1);
        chk("down_moved", moved, 1);
        chk("down_row", piece_row, 15);
        chk("down_drop_rows", drop_rows, 1);

        // Right edge rejected, left shift accepted.
        do_load(R_PC, 10);
        do_cmd(1);
        chk("right_done", done, 1);
        chk("right_moved", moved, 0);
        chk("right_shape", piece_shape, R_PC);
        do_cmd(0);
        chk("left_moved", moved, 1);
        chk("left_shape", piece_shape, R_PC_L);

        // Full bottom row, then an O-piece locking on top of it.
        do_load(BAR_PC, 0);
        do_cmd(2);
        chk("bar_locked", locked, 1);
        do_load(O_PC, 1);
        do_cmd(2);
        chk("lock_pulse", locked, 1);
        chk("lock_row0", board[9:0], 10'h3FF);
        chk("lock_rows12", board[29:10], {10'b0000110000, 10'b0000110000});
        chk("lock_active", piece_active, 0);
        chk("lock_ready", cmd_ready, 0);

        // Hard drop from row 16 on an empty board.
        do_reset();
        do_load(O_PC, 16);
        do_cmd(3);
`ifdef PIECE_MOVER_HARD_DROP_EN
        chk("drop_rows16", drop_rows, 16);
        chk("drop_locked", locked, 1);
        chk("drop_board", board[19:0], {10'b0000110000, 10'b0000110000});
`else
        chk("drop_off_moved", moved, 0);
        chk("drop_off_row", piece_row, 16);
`endif

        // Spawn overlapping a settled cell ends the game.
        do_reset();
        do_load(BAR_PC, 0);
        do_cmd(2);
        do_load(O_PC, 0);
        chk("go_flag", game_over, 1);
        chk("go_active", piece_active, 0);
        chk("go_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_dir = 2'd2;
        repeat (3) tick();
        chk("go_ready_held", cmd_ready, 0);
        cmd_valid = 1'b0;

        // Reset in the middle of a hard drop.
        do_reset();
        do_load(O_PC, 16);
        cmd_valid = 1'b1;
        cmd_dir = 2'd3;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("abort_done", done, 0);
        chk("abort_row", piece_row, 0);
        chk("abort_shape", piece_shape, 0);
        chk("abort_active", piece_active, 0);
        reset = 1'b0;

        // Load and command together: the load wins.
        do_load(O_PC, 10);
        load_valid = 1'b1;
        load_shape = O_PC;
        load_row = 5'd5;
        cmd_valid = 1'b1;
        cmd_dir = 2'd2;
        #1;
        chk("load_wins_ready", cmd_ready, 0);
        tick();
        load_valid = 1'b0;
        cmd_valid = 1'b0;
        chk("load_wins_row", piece_row, 5);
        tick();
        chk("load_wins_nodone", done, 0);

        // Randomized play.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int k;
            k = $urandom_range(0, 9);
            if (m_go) begin
                do_reset();
            end else if (!m_active || k == 0) begin
                do_load(rand_piece(), $urandom_range(6, 16));
            end else if (k == 1) begin
                load_valid = 1'b1;
                load_shape = rand_piece();
                load_row = 5'($urandom_range(6, 16));
                cmd_valid = 1'b1;
                cmd_dir = 2'($urandom_range(0, 3));
                tick();
                load_valid = 1'b0;
                cmd_valid = 1'b0;
            end else if (k == 2) begin
                repeat ($urandom_range(1, 3)) tick();
            end else if (k == 3) begin
                cmd_valid = 1'b1;
                cmd_dir = 2'($urandom_range(0, 3));
                tick();
                wait_idle();
                tick();
                cmd_valid = 1'b0;
                wait_idle();
            end else begin
                do_cmd($urandom_range(0, 3));
            end
        end
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piece_mover.md
Name: piece_mover

Overview:
- Parametrised successor to the per-direction move blocks. A single sequential unit owns the settled-block board and the active piece, and executes left, right, down and hard-drop commands through a valid/ready handshake.
- On every command it checks the board edges and collisions, then commits or rejects the move. A blocked down move locks the piece into the board.
- It sits between the input/gravity controller (command source) and the line-clear and display logic (board consumers).

Parameters:
- ROWS, 20, board height in rows; row 0 is the bottom.
- COLS, 10, board width; column bit 0 is the rightmost cell.
- WIN, 4, height and width of the piece window in rows; each row is COLS bits.
- ROW_W, $clog2(ROWS), width of the row-position fields.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  spawn a new piece; honoured only in IDLE.
- load_shape  in  WIN*COLS  piece window; row r occupies bits [r*COLS +: COLS].
- load_row  in  ROW_W  bottom row of the window; must be <= ROWS-WIN.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_dir  in  2  0=LEFT, 1=RIGHT, 2=DOWN, 3=DROP.
- board  out  ROWS*COLS  settled cells only.
- piece_shape  out  WIN*COLS  current piece window.
- piece_row  out  ROW_W  current window bottom row.
- piece_active  out  1  a piece is loaded and not yet locked.
- done  out  1  one-cycle pulse when a command completes.
- moved  out  1  qualifies done: 1 = the piece moved at least once.
- locked  out  1  one-cycle pulse, coincident with done, when the piece merges into the board.
- drop_rows  out  ROW_W  rows descended by the last command; valid with done.
- game_over  out  1  sticky; set when a loaded piece overlaps settled cells.

Behaviour:
- Reset: state=IDLE; board=0; piece_shape=0; piece_row=0; piece_active=0; done=moved=locked=0; drop_rows=0; game_over=0. Reset mid-command aborts it with no done pulse.
- States: IDLE, CHECK, DROP, LOCK.
- cmd_ready = (state==IDLE) && piece_active && !load_valid && !game_over. A load therefore always beats a simultaneous command.
- Load (IDLE && load_valid):
  - Next cycle: piece_shape=load_shape, piece_row=load_row, piece_active=1.
  - If (load_shape & board window) != 0, set game_over and hold piece_active=0.
  - A load_valid while a piece is still active replaces the piece.
- Accept cycle (T0): latch cmd_dir; go to CHECK.
- CHECK (T1): compute the candidate and test fit.
  - LEFT: each window row shifts toward the MSB; blocked if any bit[COLS-1] is set.
  - RIGHT: each window row shifts toward bit 0; blocked if any bit[0] is set.
  - DOWN: candidate row = piece_row-1; blocked if piece_row==0.
  - Collision: (candidate & board window at candidate row) != 0.
  - If free: commit, drop_rows = 1 for DOWN else 0, done=1, moved=1, return to IDLE.
  - If LEFT/RIGHT is blocked: done=1, moved=0, no state change, IDLE.
  - If DOWN is blocked: go to LOCK.
  - DROP: go to DROP.
- DROP: one row per cycle while the move-down fit passes; drop_rows increments each step (saturating at ROWS-1). When blocked, go to LOCK.
- LOCK (one cycle): board |= piece placed at piece_row; piece_active=0; done=1; locked=1; moved=(drop_rows!=0); return to IDLE.
- Throughput:
  - LEFT/RIGHT/DOWN success: done in T2, cmd_ready high again in T2.
  - Blocked DOWN: locked in T3.
  - DROP over n rows: done at T3+n.
- Board window rows at or above ROWS read as zero. Cells are never lost at the edges, because edge moves are rejected.
- No piece_active output: commands are not accepted (cmd_ready=0).

Optional Feature:
- Macro: PIECE_MOVER_HARD_DROP_EN.
- Defined: DROP behaves as described above.
- Undefined: the DROP state is not built; cmd_dir=3 completes in CHECK with done=1, moved=0, no state change.

Decomposition:
- Shared package tetris_pkg holds:
  - dir_e enum {DIR_LEFT, DIR_RIGHT, DIR_DOWN, DIR_DROP};
  - mover_state_e;
  - default constants BOARD_ROWS=20, BOARD_COLS=10, PIECE_WIN=4.
- One combinational sub-module, piece_fit_check (parameters ROWS/COLS/WIN):
  - inputs: board, candidate shape, candidate row, direction;
  - outputs: at_edge and collide.
  - It is instantiated once and fed the candidate.

Test Plan:
- Defaults; load an O-piece (rows 0,1 = 10'b0000110000) at row 16, DOWN -> done at T2, moved=1, piece_row=15, drop_rows=1.
- Piece with bit 0 set, RIGHT -> done, moved=0, shape unchanged; the same piece moved LEFT -> shape shifted toward the MSB.
- Board row 0 = 10'h3FF, O-piece at row 1, DOWN -> locked pulse at T3, board rows 1,2 hold the piece, piece_active=0, cmd_ready=0.
- (HARD_DROP_EN) empty board, O-piece at row 16, DROP -> done at T3+16 with drop_rows=16, locked=1, board rows 0,1 = 10'b0000110000.
- Load an O-piece overlapping a settled cell -> game_over=1, piece_active=0, cmd_ready stays 0 until reset.
- Assert reset in the DROP state -> next cycle all outputs at their reset values, no done pulse; load_valid and cmd_valid asserted together -> the load wins and cmd_ready=0.
